// File: rtl/fsm_detector_responder_pkg.sv
// Shared state codes, default cycle counts and counter sizing for the trigger-interface FSMs.
// Cycle defaults assume the 200 MHz system clock.
package fsm_pkg;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'h00,
    ST_DELAY   = 8'h01,
    ST_EXPOSE  = 8'h02,
    ST_READOUT = 8'h03
  } responder_state_t;

  localparam int CLOCK_MHZ             = 200;
  localparam int DEF_TRIG_DELAY_CYCLES = CLOCK_MHZ * 100 / 1000;  // 100 ns
  localparam int DEF_EXPOSURE_CYCLES   = CLOCK_MHZ * 100;         // 100 us
  localparam int DEF_PROLONG_CYCLES    = CLOCK_MHZ * 6400;        // 6400 us

  // One bit of headroom above the widest count keeps every load value representable.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fsm_detector_responder_edge.sv
// Rising-edge detector: edge_out = in & ~in_q, with in_q cleared by reset.
// Latency: combinational on in, 1-cycle history; no backpressure.
// A level held high through reset release still yields one edge.
module rising_edge_detect (
  input  logic clock,
  input  logic reset_signal,
  input  logic in,
  output logic edge_out
);

  logic in_q;

  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign edge_out = in & ~in_q;

endmodule

// File: rtl/fsm_detector_responder.sv
// Detector-side responder: trigger edge -> delay -> exposure -> readout, detector_ready low throughout.
// Latency: detector_ready drops on the edge that first samples trigger_in high; all outputs registered.
// No queueing: edges while busy are dropped and counted in a saturating overrun counter.
module fsm_detector_responder
  import fsm_pkg::*;
#(
  parameter int TRIG_DELAY_CYCLES = DEF_TRIG_DELAY_CYCLES,
  parameter int EXPOSURE_CYCLES   = DEF_EXPOSURE_CYCLES,
  parameter int PROLONG_CYCLES    = DEF_PROLONG_CYCLES,
  parameter int CNT_WIDTH         = cnt_width(TRIG_DELAY_CYCLES, EXPOSURE_CYCLES, PROLONG_CYCLES)
) (
  input  logic        clock,
  input  logic        reset_signal,
  input  logic        enable,
  input  logic        trigger_in,
  output logic        detector_ready,
  output logic        exposure_active,
  output logic [15:0] frame_counter,
  output logic [7:0]  overrun_count,
  output logic [7:0]  responder_state
);

  localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

  if (EXPOSURE_CYCLES < 1 || PROLONG_CYCLES < 1 || TRIG_DELAY_CYCLES < 0) begin : g_bad_cycles
    $error("fsm_detector_responder: EXPOSURE_CYCLES and PROLONG_CYCLES must be >= 1, TRIG_DELAY_CYCLES >= 0");
  end

  if (longint'(TRIG_DELAY_CYCLES) > CNT_MAX || longint'(EXPOSURE_CYCLES) > CNT_MAX ||
      longint'(PROLONG_CYCLES) > CNT_MAX) begin : g_bad_width
    $error("fsm_detector_responder: a cycle count does not fit in CNT_WIDTH bits");
  end

  localparam logic [CNT_WIDTH-1:0] DELAY_LOAD   = CNT_WIDTH'(TRIG_DELAY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] EXPOSE_LOAD  = CNT_WIDTH'(EXPOSURE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] PROLONG_LOAD = CNT_WIDTH'(PROLONG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam bit                   SKIP_DELAY   = (TRIG_DELAY_CYCLES == 0);

  responder_state_t     state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 trig_edge;
  logic                 cnt_last;

  rising_edge_detect u_trig_edge (
    .clock        (clock),
    .reset_signal (reset_signal),
    .in           (trigger_in),
    .edge_out     (trig_edge)
  );

  // Each state loads its own length and leaves on the cycle the count reaches 1.
  assign cnt_last        = (cnt == CNT_ONE);
  assign responder_state = state;

  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      detector_ready  <= 1'b1;
      exposure_active <= 1'b0;
      frame_counter   <= '0;
      overrun_count   <= '0;
    end else begin
      if (trig_edge && state != ST_IDLE && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (trig_edge && enable) begin
            detector_ready <= 1'b0;
            if (SKIP_DELAY) begin
              state           <= ST_EXPOSE;
              cnt             <= EXPOSE_LOAD;
              exposure_active <= 1'b1;
              frame_counter   <= frame_counter + 16'd1;
            end else begin
              state <= ST_DELAY;
              cnt   <= DELAY_LOAD;
            end
          end
        end

        ST_DELAY: begin
          if (cnt_last) begin
            state           <= ST_EXPOSE;
            cnt             <= EXPOSE_LOAD;
            exposure_active <= 1'b1;
            frame_counter   <= frame_counter + 16'd1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_EXPOSE: begin
          if (cnt_last) begin
            state           <= ST_READOUT;
            cnt             <= PROLONG_LOAD;
            exposure_active <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_READOUT: begin
          if (cnt_last) begin
            state          <= ST_IDLE;
            detector_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state           <= ST_IDLE;
          detector_ready  <= 1'b1;
          exposure_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_detector_responder.sv
// Scoreboard bench: two builds (D=4/E=10/P=50 and D=0/E=2/P=3); stimulus queues expected frames
// and snapshots, a negedge monitor measures each completed frame and pops/compares.
`timescale 1ns/100ps
module tb_fsm_detector_responder;

  logic clock = 1'b0;
  always #2.5 clock = ~clock;

  logic        rst_a, en_a, trig_a, dr_a, ea_a;
  logic [15:0] fc_a;
  logic [7:0]  oc_a, st_a;
  logic        rst_b, en_b, trig_b, dr_b, ea_b;
  logic [15:0] fc_b;
  logic [7:0]  oc_b, st_b;

  fsm_detector_responder #(
    .TRIG_DELAY_CYCLES (4),
    .EXPOSURE_CYCLES   (10),
    .PROLONG_CYCLES    (50)
  ) u_dut_a (
    .clock           (clock),
    .reset_signal    (rst_a),
    .enable          (en_a),
    .trigger_in      (trig_a),
    .detector_ready  (dr_a),
    .exposure_active (ea_a),
    .frame_counter   (fc_a),
    .overrun_count   (oc_a),
    .responder_state (st_a)
  );

  fsm_detector_responder #(
    .TRIG_DELAY_CYCLES (0),
    .EXPOSURE_CYCLES   (2),
    .PROLONG_CYCLES    (3)
  ) u_dut_b (
    .clock           (clock),
    .reset_signal    (rst_b),
    .enable          (en_b),
    .trigger_in      (trig_b),
    .detector_ready  (dr_b),
    .exposure_active (ea_b),
    .frame_counter   (fc_b),
    .overrun_count   (oc_b),
    .responder_state (st_b)
  );

  typedef struct {
    int dut;
    int low_len;
    int delay_len;
    int expose_len;
    int readout_len;
    int exp_first;
    int exp_cnt;
    int fc;
  } frame_t;

  typedef struct {
    int    dut;
    string name;
    int    dr;
    int    ea;
    int    fc;
    int    oc;
    int    st;
  } snap_t;

  frame_t frame_q[$];
  snap_t  snap_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  int in_frame[2];
  int low_len[2];
  int dly_len[2];
  int exp_len[2];
  int rdo_len[2];
  int exp_first[2];
  int exp_cnt[2];

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic rst, input logic dr, input logic ea,
                     input logic [15:0] fc, input logic [7:0] st);
    frame_t f;
    if (!rst) begin
      in_frame[d] = 0;
      return;
    end
    if (!dr) begin
      if (in_frame[d] == 0) begin
        in_frame[d]  = 1;
        low_len[d]   = 0;
        dly_len[d]   = 0;
        exp_len[d]   = 0;
        rdo_len[d]   = 0;
        exp_first[d] = 0;
        exp_cnt[d]   = 0;
      end
      low_len[d]++;
      case (st)
        8'h01:   dly_len[d]++;
        8'h02:   exp_len[d]++;
        8'h03:   rdo_len[d]++;
        default: ;
      endcase
      if (ea) begin
        exp_cnt[d]++;
        if (exp_first[d] == 0) exp_first[d] = low_len[d];
      end
    end else if (in_frame[d] != 0) begin
      in_frame[d] = 0;
      if (frame_q.size() == 0 || frame_q[0].dut != d) begin
        cmp($sformatf("unexpected_frame_dut%0d_low_len", d), low_len[d], 0);
      end else begin
        f = frame_q.pop_front();
        cmp($sformatf("dut%0d_frame%0d_low_len", d, f.fc), low_len[d], f.low_len);
        cmp($sformatf("dut%0d_frame%0d_delay_len", d, f.fc), dly_len[d], f.delay_len);
        cmp($sformatf("dut%0d_frame%0d_expose_len", d, f.fc), exp_len[d], f.expose_len);
        cmp($sformatf("dut%0d_frame%0d_readout_len", d, f.fc), rdo_len[d], f.readout_len);
        cmp($sformatf("dut%0d_frame%0d_exp_first", d, f.fc), exp_first[d], f.exp_first);
        cmp($sformatf("dut%0d_frame%0d_exp_cnt", d, f.fc), exp_cnt[d], f.exp_cnt);
        cmp($sformatf("dut%0d_frame%0d_frame_counter", d, f.fc), int'(fc), f.fc);
      end
    end
  endtask

  task automatic chk_snap(input snap_t s, input logic dr, input logic ea,
                          input logic [15:0] fc, input logic [7:0] oc, input logic [7:0] st);
    cmp({s.name, "_detector_ready"}, int'(dr), s.dr);
    cmp({s.name, "_exposure_active"}, int'(ea), s.ea);
    cmp({s.name, "_frame_counter"}, int'(fc), s.fc);
    cmp({s.name, "_overrun_count"}, int'(oc), s.oc);
    cmp({s.name, "_responder_state"}, int'(st), s.st);
  endtask

  // Monitor: measure frames and consume pending snapshots away from the active edge.
  always @(negedge clock) begin
    snap_t s;
    mon(0, rst_a, dr_a, ea_a, fc_a, st_a);
    mon(1, rst_b, dr_b, ea_b, fc_b, st_b);
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      if (s.dut == 0) chk_snap(s, dr_a, ea_a, fc_a, oc_a, st_a);
      else            chk_snap(s, dr_b, ea_b, fc_b, oc_b, st_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap(input int d, input string name, input int dr, input int ea,
                      input int fc, input int oc, input int st);
    snap_t s;
    s.dut  = d;
    s.name = name;
    s.dr   = dr;
    s.ea   = ea;
    s.fc   = fc;
    s.oc   = oc;
    s.st   = st;
    snap_q.push_back(s);
  endtask

  // Expected frame shapes: A = 4 delay + 10 expose + 50 readout, B = 0 + 2 + 3.
  task automatic push_frame(input int d, input int fc);
    if (d == 0) frame_q.push_back('{0, 64, 4, 10, 50, 5, 10, fc});
    else        frame_q.push_back('{1, 5, 0, 2, 3, 1, 2, fc});
  endtask

  task automatic pulse_a();
    trig_a = 1'b1;
    tick(1);
    trig_a = 1'b0;
  endtask

  task automatic pulse_b();
    trig_b = 1'b1;
    tick(1);
    trig_b = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    tick(2);
    rst_a = 1'b1;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) in_frame[i] = 0;
    rst_a = 1'b0; en_a = 1'b1; trig_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b1; trig_b = 1'b0;
    tick(3);
    snap(0, "reset_a", 1, 0, 0, 0, 0);
    snap(1, "reset_b", 1, 0, 0, 0, 0);
    tick(1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick(2);

    // Single pulse: one-cycle latency to DELAY, full 64-cycle frame.
    push_frame(0, 1);
    pulse_a();
    snap(0, "t1_first_low_cycle", 0, 0, 0, 0, 1);
    tick(70);
    snap(0, "t1_after_frame", 1, 0, 1, 0, 0);

    // Level held high across reset release: one edge, one frame, no overruns.
    rst_a  = 1'b0;
    trig_a = 1'b1;
    tick(2);
    rst_a = 1'b1;
    push_frame(0, 1);
    tick(200);
    trig_a = 1'b0;
    tick(5);
    snap(0, "t2_held_level", 1, 0, 1, 0, 0);

    // Overruns at window cycle 30 and on the final readout cycle; neither starts a frame.
    reset_a();
    push_frame(0, 1);
    pulse_a();
    tick(29);
    pulse_a();
    tick(33);
    pulse_a();
    tick(5);
    snap(0, "t3_overruns", 1, 0, 1, 2, 0);
    push_frame(0, 2);
    pulse_a();
    tick(70);
    snap(0, "t3_resume", 1, 0, 2, 2, 0);

    // Disabled trigger ignored; mid-sequence disable lets the frame finish, then blocks.
    reset_a();
    en_a = 1'b0;
    pulse_a();
    tick(3);
    snap(0, "t4_disabled", 1, 0, 0, 0, 0);
    en_a = 1'b1;
    push_frame(0, 1);
    pulse_a();
    tick(10);
    en_a = 1'b0;
    tick(60);
    pulse_a();
    tick(3);
    snap(0, "t4_blocked_after_disable", 1, 0, 1, 0, 0);
    en_a = 1'b1;
    tick(2);

    // One-cycle reset during EXPOSE abandons the frame.
    reset_a();
    pulse_a();
    tick(7);
    snap(0, "t5_in_expose", 0, 1, 1, 0, 2);
    rst_a = 1'b0;
    tick(1);
    rst_a = 1'b1;
    snap(0, "t5_after_reset", 1, 0, 0, 0, 0);
    push_frame(0, 1);
    pulse_a();
    tick(70);
    snap(0, "t5_full_frame", 1, 0, 1, 0, 0);

    // Zero-delay build: exposure on the first low cycle, 300 back-to-back frames.
    push_frame(1, 1);
    pulse_b();
    snap(1, "b_first_low_cycle", 0, 1, 1, 0, 2);
    tick(5);
    for (int i = 1; i < 300; i++) begin
      push_frame(1, i + 1);
      pulse_b();
      tick(5);
    end
    snap(1, "b_300_frames", 1, 0, 300, 0, 0);

    // Two busy edges per frame (expose, readout) until the overrun counter saturates.
    for (int i = 0; i < 130; i++) begin
      push_frame(1, 301 + i);
      pulse_b();
      tick(1);
      pulse_b();
      tick(1);
      pulse_b();
      tick(1);
      if (i == 126) snap(1, "b_overrun_254", 1, 0, 427, 254, 0);
      if (i == 127) snap(1, "b_overrun_255", 1, 0, 428, 255, 0);
    end
    snap(1, "b_overrun_saturated", 1, 0, 430, 255, 0);

    tick(5);
    cmp("frames_outstanding", frame_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
